// File: rtl/mldsa_op_sequencer.sv
// ML-DSA operation sequencer: steps the datapath through KEYGEN/SIGN/VERIFY programs.
// Optional WAIT watchdog enabled by defining MLDSA_SEQ_TIMEOUT_EN.
module mldsa_op_sequencer #(
  parameter int unsigned MAX_ATTEMPTS   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_pulse,
  input  logic [1:0] main_mode,
  output logic       op_valid,
  output logic [2:0] op_code,
  input  logic       op_ready,
  input  logic       op_done,
  input  logic       op_reject,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [3:0] attempt_cnt
);

  // state  | meaning
  // IDLE   | waiting for an accepted start_pulse
  // ISSUE  | op_valid high until the datapath takes the step
  // WAIT   | step running, waiting for op_done
  // NEXT   | choose next step, retry, or finish
  // FINISH | one-cycle done pulse
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [1:0] M_KEYGEN = 2'd0;
  localparam logic [1:0] M_SIGN   = 2'd1;
  localparam logic [1:0] M_VERIFY = 2'd2;

  localparam logic [2:0] OP_EXPAND_A = 3'd1;
  localparam logic [2:0] OP_SAMPLE   = 3'd2;
  localparam logic [2:0] OP_NTT      = 3'd3;
  localparam logic [2:0] OP_MATMUL   = 3'd4;
  localparam logic [2:0] OP_INTT     = 3'd5;
  localparam logic [2:0] OP_CHECK    = 3'd6;
  localparam logic [2:0] OP_PACK     = 3'd7;

  localparam logic [3:0] MAX_ATT = 4'(MAX_ATTEMPTS);
  // SIGN program index of SAMPLE, where a rejected attempt resumes
  localparam logic [2:0] SIGN_RETRY_PC = 3'd2;

  logic [2:0] state;
  logic [1:0] mode_q;
  logic [2:0] pc;
  logic       rej_q;
  logic [1:0] status_q;
  logic [3:0] attempt_q;
  logic [2:0] cur_op;

`ifdef MLDSA_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`endif

  function automatic logic [2:0] step_op(input logic [1:0] m, input logic [2:0] i);
    logic [2:0] op;
    op = 3'd0;
    case (m)
      M_KEYGEN: case (i)
        3'd0: op = OP_EXPAND_A;  3'd1: op = OP_SAMPLE;  3'd2: op = OP_NTT;
        3'd3: op = OP_MATMUL;    3'd4: op = OP_INTT;    3'd5: op = OP_PACK;
        default: op = 3'd0;
      endcase
      M_SIGN: case (i)
        3'd0: op = OP_EXPAND_A;  3'd1: op = OP_NTT;     3'd2: op = OP_SAMPLE;
        3'd3: op = OP_MATMUL;    3'd4: op = OP_INTT;    3'd5: op = OP_CHECK;
        3'd6: op = OP_PACK;
        default: op = 3'd0;
      endcase
      M_VERIFY: case (i)
        3'd0: op = OP_EXPAND_A;  3'd1: op = OP_NTT;     3'd2: op = OP_MATMUL;
        3'd3: op = OP_INTT;      3'd4: op = OP_CHECK;
        default: op = 3'd0;
      endcase
      default: op = 3'd0;
    endcase
    return op;
  endfunction

  function automatic logic [2:0] last_pc(input logic [1:0] m);
    case (m)
      M_KEYGEN: return 3'd5;
      M_SIGN:   return 3'd6;
      default:  return 3'd4;
    endcase
  endfunction

  assign cur_op      = step_op(mode_q, pc);
  assign op_valid    = (state == S_ISSUE);
  assign op_code     = op_valid ? cur_op : 3'd0;
  assign busy        = (state == S_ISSUE) || (state == S_WAIT) || (state == S_NEXT);
  assign done        = (state == S_FINISH);
  assign status      = status_q;
  assign attempt_cnt = attempt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      mode_q    <= M_KEYGEN;
      pc        <= 3'd0;
      rej_q     <= 1'b0;
      status_q  <= 2'd0;
      attempt_q <= 4'd0;
`ifdef MLDSA_SEQ_TIMEOUT_EN
      tmo_cnt   <= 16'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_pulse) begin
            mode_q <= main_mode;
            pc     <= 3'd0;
            rej_q  <= 1'b0;
            if (main_mode == 2'd3) begin
              status_q  <= 2'd3;
              attempt_q <= 4'd0;
              state     <= S_FINISH;
            end else begin
              status_q  <= 2'd0;
              attempt_q <= (main_mode == M_SIGN) ? 4'd1 : 4'd0;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (op_ready) begin
            state <= S_WAIT;
`ifdef MLDSA_SEQ_TIMEOUT_EN
            tmo_cnt <= 16'd0;
`endif
          end
        end
        S_WAIT: begin
          if (op_done) begin
            rej_q <= op_reject;
            state <= S_NEXT;
          end
`ifdef MLDSA_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            status_q <= 2'd3;
            state    <= S_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        S_NEXT: begin
          if (cur_op == OP_CHECK && rej_q) begin
            if (mode_q == M_VERIFY) begin
              status_q <= 2'd1;
              state    <= S_FINISH;
            end else if (attempt_q < MAX_ATT) begin
              attempt_q <= (attempt_q == 4'hF) ? 4'hF : attempt_q + 4'd1;
              pc        <= SIGN_RETRY_PC;
              state     <= S_ISSUE;
            end else begin
              status_q <= 2'd2;
              state    <= S_FINISH;
            end
          end else if (pc == last_pc(mode_q)) begin
            state <= S_FINISH;
          end else begin
            pc    <= pc + 3'd1;
            state <= S_ISSUE;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mldsa_op_sequencer.sv
// Directed bench for mldsa_op_sequencer with a one-cycle-latency datapath responder.
// Define MLDSA_SEQ_TIMEOUT_EN for both files to exercise the watchdog build.
module tb_mldsa_op_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start_pulse;
  logic [1:0] main_mode;
  logic       op_valid;
  logic [2:0] op_code;
  logic       op_ready;
  logic       op_done;
  logic       op_reject;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [3:0] attempt_cnt;

  int errs = 0;
  int checks = 0;

  logic [63:0] seq;
  int nsteps, nchecks, done_cyc, busy_gaps, last_op;
  logic busy_at_done, valid_seen;

  mldsa_op_sequencer #(.MAX_ATTEMPTS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .start_pulse(start_pulse), .main_mode(main_mode),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
    .op_reject(op_reject), .busy(busy), .done(done), .status(status),
    .attempt_cnt(attempt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start one operation from IDLE and play the datapath: op_done one cycle after
  // acceptance, CHECK rejected while fewer than rej_n CHECKs have been seen.
  task automatic run_op(input logic [1:0] mode, input int rej_n, input bit no_done,
                        input int max_cyc);
    bit pend, pend_rej;
    int c;
    seq = '0; nsteps = 0; nchecks = 0; done_cyc = 0; busy_gaps = 0; last_op = 0;
    busy_at_done = 1'b1; valid_seen = 1'b0;
    pend = 0; pend_rej = 0;
    op_ready = 1'b1;
    @(posedge clk); #1;
    start_pulse = 1'b1;
    main_mode   = mode;
    @(posedge clk); #1;
    start_pulse = 1'b0;
    main_mode   = ~mode;
    c = 1;
    while (c <= max_cyc) begin
      op_done   = pend && !no_done;
      op_reject = pend_rej;
      pend = 0; pend_rej = 0;
      if (op_valid) valid_seen = 1'b1;
      if (op_valid && op_ready) begin
        seq = {seq[59:0], 1'b0, op_code};
        nsteps++;
        last_op = int'(op_code);
        if (op_code == 3'd6) begin
          pend_rej = (nchecks < rej_n);
          nchecks++;
        end
        pend = 1;
      end
      if (done) begin
        done_cyc = c;
        busy_at_done = busy;
        break;
      end
      if (!busy) busy_gaps++;
      @(posedge clk); #1;
      c++;
    end
    op_done = 1'b0;
    op_reject = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_op_valid"}, longint'(op_valid), 0);
    chk({tag, "_op_code"}, longint'(op_code), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_status"}, longint'(status), 0);
    chk({tag, "_attempt"}, longint'(attempt_cnt), 0);
  endtask

  initial begin
    resetn = 1'b0; start_pulse = 1'b0; main_mode = 2'd0;
    op_ready = 1'b1; op_done = 1'b0; op_reject = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // KEYGEN baseline
    run_op(2'd0, 0, 0, 200);
    chk("kg_seq", longint'(seq), 64'h123457);
    chk("kg_done_cyc", done_cyc, 19);
    chk("kg_status", longint'(status), 0);
    chk("kg_attempt", longint'(attempt_cnt), 0);
    chk("kg_busy_gaps", busy_gaps, 0);
    chk("kg_busy_at_done", longint'(busy_at_done), 0);

    // SIGN accepted first time
    run_op(2'd1, 0, 0, 200);
    chk("sg0_seq", longint'(seq), 64'h1324567);
    chk("sg0_done_cyc", done_cyc, 22);
    chk("sg0_status", longint'(status), 0);
    chk("sg0_attempt", longint'(attempt_cnt), 1);

    // SIGN rejected twice, then accepted
    run_op(2'd1, 2, 0, 200);
    chk("sg2_seq", longint'(seq), 64'h132456245624567);
    chk("sg2_checks", nchecks, 3);
    chk("sg2_done_cyc", done_cyc, 46);
    chk("sg2_status", longint'(status), 0);
    chk("sg2_attempt", longint'(attempt_cnt), 3);

    // SIGN always rejected: attempts exhausted
    run_op(2'd1, 99, 0, 300);
    chk("sgx_steps", nsteps, 34);
    chk("sgx_checks", nchecks, 8);
    chk("sgx_last_op", last_op, 6);
    chk("sgx_done_cyc", done_cyc, 103);
    chk("sgx_status", longint'(status), 2);
    chk("sgx_attempt", longint'(attempt_cnt), 8);

    // reserved mode
    run_op(2'd3, 0, 0, 50);
    chk("bad_done_cyc", done_cyc, 1);
    chk("bad_valid_seen", longint'(valid_seen), 0);
    chk("bad_status", longint'(status), 3);
    repeat (2) @(posedge clk);
    #1 chk("bad_status_held", longint'(status), 3);

    // VERIFY fail then pass
    run_op(2'd2, 1, 0, 200);
    chk("vf_seq", longint'(seq), 64'h13456);
    chk("vf_done_cyc", done_cyc, 16);
    chk("vf_status", longint'(status), 1);
    chk("vf_attempt", longint'(attempt_cnt), 0);
    run_op(2'd2, 0, 0, 200);
    chk("vp_status", longint'(status), 0);
    chk("vp_done_cyc", done_cyc, 16);

    // backpressure, ignored start while busy, stray op_done, reset mid-WAIT
    @(posedge clk); #1;
    op_ready = 1'b0;
    start_pulse = 1'b1; main_mode = 2'd1;
    @(posedge clk); #1;
    start_pulse = 1'b0;
    op_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), longint'(op_valid), 1);
      chk($sformatf("bp_code_%0d", i), longint'(op_code), 1);
      start_pulse = (i == 1);
      main_mode = 2'd2;
      @(posedge clk); #1;
    end
    start_pulse = 1'b0;
    op_ready = 1'b1;
    chk("bp_code_accept", longint'(op_code), 1);
    @(posedge clk); #1;
    op_done = 1'b0;
    op_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait_valid_%0d", i), longint'(op_valid), 0);
      chk($sformatf("wait_busy_%0d", i), longint'(busy), 1);
      @(posedge clk); #1;
    end
    chk("pre_rst_attempt", longint'(attempt_cnt), 1);
    resetn = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1;
    chk("midrst_no_done", longint'(done), 0);
    resetn = 1'b1;
    run_op(2'd0, 0, 0, 200);
    chk("fresh_seq", longint'(seq), 64'h123457);
    chk("fresh_done_cyc", done_cyc, 19);
    chk("fresh_status", longint'(status), 0);

    // op_done withheld in WAIT
`ifdef MLDSA_SEQ_TIMEOUT_EN
    run_op(2'd0, 0, 1, 60);
    chk("tmo_steps", nsteps, 1);
    chk("tmo_done_cyc", done_cyc, 18);
    chk("tmo_status", longint'(status), 3);
`else
    run_op(2'd0, 0, 1, 40);
    chk("hold_steps", nsteps, 1);
    chk("hold_no_done", done_cyc, 0);
    chk("hold_busy", longint'(busy), 1);
    resetn = 1'b0;
    #1 check_reset_outputs("hold_rst");
    @(posedge clk); #1 resetn = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mldsa_op_sequencer.md
MLDSA_OP_SEQUENCER -- requirements
Module: mldsa_op_sequencer

Interface
REQ-001 Parameter MAX_ATTEMPTS, default 8: signing rejection-loop limit, range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: WAIT-state watchdog limit, 16-bit.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start_pulse  input  1  one-cycle operation start from the control register slave.
REQ-006 main_mode  input  2  0=KEYGEN, 1=SIGN, 2=VERIFY, 3=reserved; sampled only on an accepted start_pulse.
REQ-007 op_valid  output  1  step command valid to the datapath.
REQ-008 op_code  output  3  step: 1 EXPAND_A, 2 SAMPLE, 3 NTT, 4 MATMUL, 5 INTT, 6 CHECK, 7 PACK.
REQ-009 op_ready  input  1  datapath accepts the command.
REQ-010 op_done  input  1  one-cycle completion of the current step.
REQ-011 op_reject  input  1  CHECK result, valid only with op_done; 1 = reject/fail.
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 status  output  2  0 OK, 1 verify fail, 2 attempts exhausted, 3 bad mode/timeout; held until the next accepted start.
REQ-015 attempt_cnt  output  4  SIGN attempts used in the current or last operation.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, NEXT, FINISH.
- IDLE->ISSUE on start_pulse with mode 0..2.
- ISSUE->WAIT on op_valid&&op_ready.
- WAIT->NEXT on op_done.
- NEXT->ISSUE or FINISH.
- FINISH->IDLE.
REQ-017 Step programs SHALL be:
- KEYGEN: EXPAND_A, SAMPLE, NTT, MATMUL, INTT, PACK.
- SIGN: EXPAND_A, NTT, SAMPLE, MATMUL, INTT, CHECK, PACK.
- VERIFY: EXPAND_A, NTT, MATMUL, INTT, CHECK.
REQ-018 op_valid SHALL be high exactly in ISSUE; op_code SHALL be stable while op_valid&&!op_ready.
REQ-019 op_done SHALL be ignored outside WAIT, including the cycle in which the command is accepted.
REQ-020 SIGN CHECK with op_reject=1: if attempt_cnt<MAX_ATTEMPTS, increment attempt_cnt and resume at SAMPLE; otherwise FINISH with status 2.
REQ-021 attempt_cnt SHALL be 1 at the first SIGN attempt, 0 for other modes, and saturate at 15.
REQ-022 VERIFY CHECK with op_reject=1: FINISH with status 1; op_reject=0: status 0.
REQ-023 start_pulse with mode 3 in IDLE SHALL go directly to FINISH, status 3, no op_valid issued.
REQ-024 start_pulse while busy SHALL be ignored; main_mode changes while busy SHALL have no effect.
REQ-025 With op_ready=1 and op_done one cycle after issue, done SHALL rise 3N+1 cycles after the start_pulse cycle, N = steps executed (KEYGEN: 19).
REQ-026 done SHALL be high only in FINISH; busy SHALL fall in the same cycle done is asserted.

Reset
REQ-027 Asserting resetn low SHALL force IDLE immediately, including mid-operation, with no done pulse.
REQ-028 Reset values SHALL be: op_valid=0, op_code=0, busy=0, done=0, status=0, attempt_cnt=0.
REQ-029 After reset release, the first accepted start_pulse SHALL behave as a fresh operation.

Configuration
REQ-030 With MLDSA_SEQ_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each cycle in WAIT.
- Reaching TIMEOUT_CYCLES without op_done SHALL go to FINISH with status 3.
REQ-031 With MLDSA_SEQ_TIMEOUT_EN undefined, no counter SHALL exist and WAIT SHALL hold indefinitely.

Verification
REQ-032 KEYGEN, op_ready=1, op_done 1 cycle after issue -> op_code sequence 1,2,3,4,5,7; done at cycle 19; status 0.
REQ-033 SIGN with op_reject=1 on the first two CHECKs, then 0 -> SAMPLE reissued twice; attempt_cnt=3; status 0; final op PACK.
REQ-034 SIGN with op_reject always 1, MAX_ATTEMPTS=8 -> exactly 8 CHECKs, no PACK, status 2, attempt_cnt=8.
REQ-035 mode 3 start -> done 1 cycle later, status 3, op_valid never high; then a VERIFY with reject at CHECK -> status 1.
REQ-036 op_ready held low 5 cycles in ISSUE, start_pulse injected while busy, resetn pulsed during WAIT -> op_code stable, second start ignored, all outputs at reset values.
REQ-037 With MLDSA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, op_done withheld -> done after 16 WAIT cycles, status 3.
